// File: rtl/serial_rx_param.sv
// Purpose: parameterised UART receiver (oversampled, optional parity, 1-2 stop bits) with a one-word output holding register.
// Latency: word is presented one clk after the centre sample of the last stop bit; rx has a 2-flop synchronizer in front.
// Backpressure: word is held until rx_valid&rx_ready; a new frame completing over an unconsumed word overwrites it and flags overrun.
module serial_rx_param #(
  parameter int unsigned BAUD_DIV   = 326,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             STP_LAST = (STOP_BITS == 2);
  localparam logic             ODD_PAR  = (PARITY == 1);
  localparam logic             HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Synchronizer flops idle high so reset never looks like a start edge.
  logic sync1_q, sync2_q;
  logic rx_s;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  state_t                 state_q, state_d;
  logic [SMP_W-1:0]       smp_q, smp_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stp_q, stp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_pend_q, par_pend_d;
  logic                   frm_pend_q, frm_pend_d;
  logic                   done;
  logic                   exp_par;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  // Two-flop synchronizer on the asynchronous serial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Free-running oversample divider; tick is the cycle it sits at its maximum.
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  // Divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Expected parity bit: even mode matches XOR of data, odd mode its inverse.
  assign exp_par = (^shift_q) ^ ODD_PAR;

  // Receive FSM next-state: half-bit start qualification, then centre sampling of each bit.
  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    bit_d      = bit_q;
    stp_d      = stp_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          smp_d      = '0;
          bit_d      = '0;
          stp_d      = 1'b0;
          par_pend_d = 1'b0;
          frm_pend_d = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          if (smp_q == SMP_HALF) begin
            smp_d   = '0;
            // A line that is high again at mid-start was a glitch.
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (smp_q == SMP_LAST) begin
            smp_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = HAS_PAR ? S_PAR : S_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end

      S_PAR: begin
        if (tick) begin
          if (smp_q == SMP_LAST) begin
            smp_d   = '0;
            state_d = S_STOP;
            if (rx_s != exp_par) begin
              par_pend_d = 1'b1;
            end
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (smp_q == SMP_LAST) begin
            smp_d = '0;
            if (!rx_s) begin
              frm_pend_d = 1'b1;
            end
            // Leaving mid stop bit lets the next start edge be seen right away.
            if (stp_q == STP_LAST) begin
              state_d = S_IDLE;
              done    = 1'b1;
            end else begin
              stp_d = 1'b1;
            end
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        smp_d   = '0;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      smp_q      <= '0;
      bit_q      <= '0;
      stp_q      <= 1'b0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      stp_q      <= stp_d;
      shift_q    <= shift_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
    end
  end

  // Output holding register: load on completion, clear on handshake, flag overwrite of an unconsumed word.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (done) begin
      rx_data_d    = shift_q;
      rx_valid_d   = 1'b1;
      parity_err_d = par_pend_q;
      frame_err_d  = frm_pend_d;
      overrun_d    = rx_valid_q & ~rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param: an 8N1 instance and an 8E1 instance on one clock.
// Each bit is held for 64 clk (BAUD_DIV=4, OVERSAMPLE=16); inputs change and outputs are sampled 1 time unit after posedge.
// Failed comparisons are reported through $error and counted; one summary line ends the run.
module tb_serial_rx_param;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       rx_a = 1'b1, ready_a = 1'b0;
  logic [7:0] data_a;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;

  logic       rx_b = 1'b1, ready_b = 1'b0;
  logic [7:0] data_b;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_rx_param #(
    .BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .busy(busy_a)
  );

  serial_rx_param #(
    .BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .busy(busy_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_rx(input bit use_b, input logic v);
    if (use_b) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic drive_bit(input bit use_b, input logic v);
    set_rx(use_b, v);
    step(BIT_CLKS);
  endtask

  // Start bit plus eight data bits, LSB first.
  task automatic send_head(input bit use_b, input logic [7:0] d);
    drive_bit(use_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(use_b, d[i]);
  endtask

  initial begin
    bit         seen;
    logic [7:0] got_data;
    logic       got_ovr;

    // Reset state while held in reset.
    step(5);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_data",  32'(data_a), 0);
    check("rst_flags", 32'({perr_a, ferr_a, ovr_a}), 0);
    check("rst_busy",  32'(busy_a), 0);
    rst = 1'b1;
    step(10);

    // Even parity, 0x03 (XOR of data = 0): parity bit 1 is wrong, 0 is right.
    send_head(1'b1, 8'h03); drive_bit(1'b1, 1'b1); drive_bit(1'b1, 1'b1);
    check("par_bad_valid", 32'(valid_b), 1);
    check("par_bad_data",  32'(data_b), 32'h03);
    check("par_bad_perr",  32'(perr_b), 1);
    check("par_bad_ferr",  32'(ferr_b), 0);
    ready_b = 1'b1; step(1); ready_b = 1'b0;
    check("par_ack_valid", 32'(valid_b), 0);
    check("par_ack_perr",  32'(perr_b), 0);
    send_head(1'b1, 8'h03); drive_bit(1'b1, 1'b0); drive_bit(1'b1, 1'b1);
    check("par_ok_valid", 32'(valid_b), 1);
    check("par_ok_data",  32'(data_b), 32'h03);
    check("par_ok_perr",  32'(perr_b), 0);
    ready_b = 1'b1; step(1); ready_b = 1'b0;

    // 8N1 0xA5 held while not ready, released by a one-clk ready.
    send_head(1'b0, 8'hA5); drive_bit(1'b0, 1'b1);
    check("a5_valid", 32'(valid_a), 1);
    check("a5_data",  32'(data_a), 32'hA5);
    check("a5_flags", 32'({perr_a, ferr_a, ovr_a}), 0);
    step(100);
    check("a5_hold_valid", 32'(valid_a), 1);
    check("a5_hold_data",  32'(data_a), 32'hA5);
    ready_a = 1'b1; step(1); ready_a = 1'b0;
    check("a5_ack_valid", 32'(valid_a), 0);

    // 0x3C with a low stop bit (low across the centre sample only, then idle).
    send_head(1'b0, 8'h3C);
    set_rx(1'b0, 1'b0); step(40);
    set_rx(1'b0, 1'b1); step(84);
    check("ferr_valid", 32'(valid_a), 1);
    check("ferr_data",  32'(data_a), 32'h3C);
    check("ferr_flag",  32'(ferr_a), 1);
    check("ferr_perr",  32'(perr_a), 0);
    check("ferr_idle",  32'(busy_a), 0);
    ready_a = 1'b1; step(1); ready_a = 1'b0;
    check("ferr_ack_flag", 32'(ferr_a), 0);

    // False start: 20 clk low pulse is rejected at mid-start.
    set_rx(1'b0, 1'b0); step(20); set_rx(1'b0, 1'b1);
    check("fs_busy", 32'(busy_a), 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (!busy_a) seen = 1'b1;
    end
    check("fs_busy_clear", 32'(seen), 1);
    step(50);
    check("fs_no_valid", 32'(valid_a), 0);

    // Back-to-back 0x11, 0x22 with no consumer: second overwrites first.
    send_head(1'b0, 8'h11); drive_bit(1'b0, 1'b1);
    send_head(1'b0, 8'h22); drive_bit(1'b0, 1'b1);
    check("ovr_valid", 32'(valid_a), 1);
    check("ovr_data",  32'(data_a), 32'h22);
    check("ovr_flag",  32'(ovr_a), 1);
    check("ovr_other", 32'({perr_a, ferr_a}), 0);

    // 0x33 with the consumer ready through the stop bit.
    send_head(1'b0, 8'h33);
    set_rx(1'b0, 1'b1);
    ready_a = 1'b1; step(1);
    check("r33_old_taken", 32'(valid_a), 0);
    seen = 1'b0; got_data = '0; got_ovr = 1'b1;
    for (int i = 0; i < BIT_CLKS - 1 && !seen; i++) begin
      step(1);
      if (valid_a) begin
        seen = 1'b1; got_data = data_a; got_ovr = ovr_a;
      end
    end
    step(1); ready_a = 1'b0;
    check("r33_seen", 32'(seen), 1);
    check("r33_data", 32'(got_data), 32'h33);
    check("r33_ovr",  32'(got_ovr), 0);
    check("r33_consumed", 32'(valid_a), 0);
    step(BIT_CLKS);

    // Reset in bit 4 of 0xFF discards the partial frame.
    set_rx(1'b0, 1'b0); step(BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    step(32);
    rst = 1'b0; step(1);
    check("mid_rst_busy",  32'(busy_a), 0);
    check("mid_rst_valid", 32'(valid_a), 0);
    step(3); rst = 1'b1;
    step(100);
    check("post_rst_valid", 32'(valid_a), 0);
    check("post_rst_busy",  32'(busy_a), 0);
    send_head(1'b0, 8'h5A); drive_bit(1'b0, 1'b1);
    check("5a_valid", 32'(valid_a), 1);
    check("5a_data",  32'(data_a), 32'h5A);
    check("5a_ovr",   32'(ovr_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_param.md
SERIAL_RX_PARAM -- requirements
Module: serial_rx_param

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 326, clk cycles per oversample tick (range 2..65535).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, ticks per bit period (even, 8..16).
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 SHALL have port rx_data  output  DATA_BITS  last received data word.
REQ-010 SHALL have port rx_valid  output  1  rx_data and status flags valid.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts word when high with rx_valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch for the held word; 0 when PARITY=0.
REQ-013 SHALL have port frame_err  output  1  any stop-bit sample low for the held word.
REQ-014 SHALL have port overrun  output  1  held word overwrote an unconsumed word.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-017 SHALL run a free-running divider 0..BAUD_DIV-1, asserting a one-clk tick when it equals BAUD_DIV-1, then wrapping to 0.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PAR, STOP; only tick cycles advance the sample counter (0..OVERSAMPLE-1).
REQ-019 IDLE: on rx_s=0 in any clk cycle, SHALL enter START with sample counter cleared.
REQ-020 START: on the tick where counter reaches OVERSAMPLE/2-1, SHALL enter DATA if rx_s=0, else return to IDLE (false start, no output change); counter cleared.
REQ-021 DATA/PAR/STOP: SHALL sample rx_s on the tick where counter reaches OVERSAMPLE-1 (bit centre), then clear counter.
REQ-022 DATA: SHALL shift samples into a DATA_BITS register LSB first; after DATA_BITS samples go to PAR if PARITY!=0, else STOP.
REQ-023 PAR: SHALL compare sample to XOR of data bits (inverted for odd mode); mismatch sets pending parity error; then STOP.
REQ-024 STOP: SHALL take STOP_BITS samples; any 0 sets pending frame error; after the last sample SHALL return to IDLE on that same tick.
REQ-025 Frame completion (last stop sample tick): on the next clk edge rx_data, parity_err, frame_err SHALL load and rx_valid SHALL be 1; frames with errors are still delivered.
REQ-026 rx_valid, rx_data and flags SHALL hold until a clk edge with rx_valid=1 and rx_ready=1, after which rx_valid, parity_err, frame_err, overrun clear to 0.
REQ-027 Completion while rx_valid=1 without handshake in that cycle SHALL overwrite rx_data and flags and set overrun=1.
REQ-028 Completion in the same cycle as a handshake SHALL load the new word, keep rx_valid=1, overrun=0.
REQ-029 A start edge SHALL be accepted in IDLE the cycle after STOP exits, allowing back-to-back frames with no idle gap beyond half the stop bit.
REQ-030 Counters SHALL be sized ceil(log2) of their range; no wrap beyond declared maxima.

Reset
REQ-031 rst=0 SHALL asynchronously force: FSM IDLE, divider and sample counters 0, synchronizer flops 1, shift register 0, rx_data 0, rx_valid 0, all flags 0, busy 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; no rx_valid pulse after release until a complete new frame.
REQ-033 After rst rises, the first start edge SHALL be detected no earlier than 2 clk edges later (synchronizer latency).

Verification (BAUD_DIV=4, OVERSAMPLE=16, i.e. 64 clk/bit, unless stated)
REQ-034 8N1 byte 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, all flags 0; held until rx_ready=1 for one clk, then rx_valid=0.
REQ-035 PARITY=2, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1; same with parity bit 0 -> parity_err=0.
REQ-036 8N1 0x3C with stop bit driven 0 -> rx_data=0x3C, frame_err=1, FSM back in IDLE.
REQ-037 rx low for 20 clk then high -> no rx_valid, busy returns 0 within 32 clk of the falling edge.
REQ-038 Two back-to-back frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x22, overrun=1; then send 0x33 with rx_ready=1 at completion -> rx_data=0x33, overrun=0.
REQ-039 rst=0 during bit 4 of 0xFF, release, send 0x5A -> only one rx_valid, rx_data=0x5A.
